// File: rtl/udp_vlg_tx_arb_if.sv
// UDP transmit handshake bundle: byte payload stream, datagram metadata and the
// rdy/req/ack/done control exchanged between tx sources and the UDP tx block.
interface udp;
    logic        strm_val;
    logic [7:0]  strm_data;
    logic        strm_eof;
    logic        strm_err;
    logic [31:0] meta;
    logic        rdy;
    logic        req;
    logic        ack;
    logic        done;

    // in_tx: arbiter side facing a source; out_tx: arbiter side facing UDP tx
    modport in_tx (
        input  strm_val, strm_data, strm_eof, strm_err, meta, rdy,
        output req, ack, done
    );

    modport out_tx (
        output strm_val, strm_data, strm_eof, strm_err, meta, rdy,
        input  req, ack, done
    );
endinterface

// File: rtl/udp_vlg_tx_arb.sv
// Round-robin arbiter sharing one UDP tx path between N sources, one datagram per grant.
// Optional watchdog abort is compiled in with UDP_VLG_TX_ARB_WATCHDOG_EN.
module udp_vlg_tx_arb #(
    parameter int N       = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    udp.in_tx                    src [N],
    udp.out_tx                   dst,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic                 to_err
);
    // state  | meaning
    // IDLE   | sample src rdy, pick next owner from ptr, latch its meta
    // GRANT  | offer meta downstream, wait for dst.req
    // STREAM | pipe owner's beats one cycle late until eof or early done
    // WAIT   | route ack/done from UDP tx back to the owner
    localparam int IW = $clog2(N);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] WAIT   = 2'd3;

    if (N < 2 || N > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("udp_vlg_tx_arb: N must be 2..8 and TIMEOUT 2..65535");
    end

    logic [1:0]    state, state_nxt;
    logic [IW-1:0] sel, ptr, pick, sel_inc;
    logic          any_rdy, beat, wd_hit;
    logic [31:0]   meta_q;

    logic [N-1:0]  s_rdy, s_val, s_eof, s_err;
    logic [7:0]    s_data [N];
    logic [31:0]   s_meta [N];

    logic          q_val, q_eof, q_err;
    logic [7:0]    q_data;

    for (genvar g = 0; g < N; g++) begin : g_src
        assign s_rdy[g]  = src[g].rdy;
        assign s_val[g]  = src[g].strm_val;
        assign s_eof[g]  = src[g].strm_eof;
        assign s_err[g]  = src[g].strm_err;
        assign s_data[g] = src[g].strm_data;
        assign s_meta[g] = src[g].meta;

        // gated by rst_n so a reset cycle never leaks a partial handshake pulse
        assign src[g].req  = rst_n && (sel == IW'(g)) && (state == GRANT) && dst.req;
        assign src[g].ack  = rst_n && (sel == IW'(g)) && (state == WAIT) && dst.ack;
        assign src[g].done = rst_n && (sel == IW'(g)) &&
                             (wd_hit || ((state == STREAM || state == WAIT) && dst.done));
    end

    // scan downward so the lowest offset from ptr is the one that sticks
    always_comb begin
        int idx;
        idx     = 0;
        any_rdy = |s_rdy;
        pick    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (s_rdy[IW'(idx)]) pick = IW'(idx);
        end
    end

    assign sel_inc = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
    assign beat    = s_val[sel];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_rdy) state_nxt = GRANT;
            GRANT:   if (dst.req) state_nxt = STREAM;
            STREAM: begin
                if (dst.done)                 state_nxt = IDLE;
                else if (beat && s_eof[sel])  state_nxt = WAIT;
            end
            WAIT:    if (dst.done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wd_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            ptr    <= '0;
            meta_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_rdy) begin
                sel    <= pick;
                meta_q <= s_meta[pick];
            end
            if (state != IDLE && state_nxt == IDLE) ptr <= sel_inc;
        end
    end

    // early done drops the beat in flight; a watchdog abort in STREAM closes the frame with err
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_val  <= 1'b0;
            q_eof  <= 1'b0;
            q_err  <= 1'b0;
            q_data <= '0;
        end else if (wd_hit && state == STREAM) begin
            q_val  <= 1'b1;
            q_eof  <= 1'b1;
            q_err  <= 1'b1;
            q_data <= '0;
        end else if (state == STREAM && !dst.done) begin
            q_val  <= s_val[sel];
            q_eof  <= s_eof[sel];
            q_err  <= s_err[sel];
            q_data <= s_data[sel];
        end else begin
            q_val  <= 1'b0;
            q_eof  <= 1'b0;
            q_err  <= 1'b0;
            q_data <= '0;
        end
    end

`ifdef UDP_VLG_TX_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;

    // fires on the cycle the count would step onto TIMEOUT; a live beat re-arms instead
    assign wd_hit = (state != IDLE) && (wd_cnt == 16'(TIMEOUT - 1)) &&
                    !(state == STREAM && beat);

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE || state_nxt != state || (state == STREAM && beat))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    assign dst.strm_val  = q_val;
    assign dst.strm_eof  = q_eof;
    assign dst.strm_err  = q_err;
    assign dst.strm_data = q_data;
    assign dst.meta      = meta_q;
    assign dst.rdy       = rst_n && (state == GRANT);

    assign grant_id = sel;
    assign busy     = (state != IDLE);
    assign to_err   = rst_n && wd_hit;
endmodule

// File: tb/tb_udp_vlg_tx_arb.sv
// Randomized bench for udp_vlg_tx_arb: round-robin model, stream delay, isolation,
// early done, mid-stream reset, and watchdog/hang behaviour depending on the macro.
module tb_udp_vlg_tx_arb;
    localparam int N       = 3;
    localparam int TIMEOUT = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       busy, to_err;

    udp src_if [N] ();
    udp dst_if ();

    logic [N-1:0] s_rdy, s_val, s_eof, s_err, s_req, s_ack, s_done;
    logic [7:0]   s_data [N];
    logic [31:0]  s_meta [N];

    for (genvar g = 0; g < N; g++) begin : g_src
        assign src_if[g].rdy       = s_rdy[g];
        assign src_if[g].strm_val  = s_val[g];
        assign src_if[g].strm_eof  = s_eof[g];
        assign src_if[g].strm_err  = s_err[g];
        assign src_if[g].strm_data = s_data[g];
        assign src_if[g].meta      = s_meta[g];
        assign s_req[g]  = src_if[g].req;
        assign s_ack[g]  = src_if[g].ack;
        assign s_done[g] = src_if[g].done;
    end

    udp_vlg_tx_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src      (src_if),
        .dst      (dst_if),
        .grant_id (grant_id),
        .busy     (busy),
        .to_err   (to_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ptr_m = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return 0;
    endfunction

    task automatic garbage(input int e);
        for (int i = 0; i < N; i++) begin
            if (i != e) begin
                s_val[i]  = 1'($urandom);
                s_eof[i]  = 1'($urandom);
                s_err[i]  = 1'($urandom);
                s_data[i] = 8'($urandom);
            end
        end
    endtask

    task automatic idle_srcs();
        s_val = '0;
        s_eof = '0;
        s_err = '0;
    endtask

    // mode: 0 normal eof, 1 early done, 2 stall without eof, 3 reset during beat 5
    task automatic dg(input logic [N-1:0] mask, input int nb, input int mode, input bit gaps);
        int e, b, w;
        logic [N-1:0] one;
        logic [31:0]  m;
        logic         pv, pe, pr, go, flag;
        logic [7:0]   pd;
        e = rr_pick(mask);
        one = '0;
        one[e] = 1'b1;
        for (int i = 0; i < N; i++) s_meta[i] = $urandom;
        m = s_meta[e];
        check("idle_busy", 32'(busy), 0);
        s_rdy = mask;
        cyc();
        check("grant_rdy", 32'(dst_if.rdy), 1);
        check("grant_id", 32'(grant_id), e);
        check("grant_meta", dst_if.meta, m);
        w = $urandom_range(0, 2);
        repeat (w) begin
            cyc();
            check("grant_hold", 32'(dst_if.rdy), 1);
        end
        dst_if.req = 1'b1;
        #1;
        check("src_req", 32'(s_req), 32'(one));
        cyc();
        dst_if.req = 1'b0;
        s_rdy[e]   = 1'b0;
        check("rdy_drop", 32'(dst_if.rdy), 0);

        pv = 0; pd = 0; pe = 0; pr = 0; b = 0;
        while (b < nb) begin
            check("strm_val", 32'(dst_if.strm_val), 32'(pv));
            if (pv) begin
                check("strm_data", 32'(dst_if.strm_data), 32'(pd));
                check("strm_eof", 32'(dst_if.strm_eof), 32'(pe));
                check("strm_err", 32'(dst_if.strm_err), 32'(pr));
            end
            check("iso_ctl", 32'(s_req | s_ack | s_done), 0);
            garbage(e);
            go = !gaps || ($urandom_range(0, 3) != 0);
            s_val[e]  = go;
            s_data[e] = 8'($urandom);
            s_eof[e]  = (mode == 0) && (b == nb - 1);
            s_err[e]  = 1'($urandom);
            pv = go; pd = s_data[e]; pe = s_eof[e]; pr = s_err[e];
            if (mode == 3 && b == 4 && go) begin
                rst_n       = 1'b0;
                dst_if.done = 1'b1;
                #1;
                check("rst_no_pulse", 32'(s_req | s_ack | s_done), 0);
                check("rst_no_rdy", 32'(dst_if.rdy), 0);
                cyc();
                rst_n       = 1'b1;
                dst_if.done = 1'b0;
                idle_srcs();
                s_rdy = '0;
                check("rst_busy", 32'(busy), 0);
                check("rst_gid", 32'(grant_id), 0);
                check("rst_to_err", 32'(to_err), 0);
                check("rst_strm", {dst_if.strm_val, dst_if.strm_eof, dst_if.strm_err, dst_if.strm_data}, 0);
                check("rst_meta", dst_if.meta, 0);
                ptr_m = 0;
                return;
            end
            if (go) b++;
            cyc();
        end

        check("last_val", 32'(dst_if.strm_val), 32'(pv));
        check("last_data", 32'(dst_if.strm_data), 32'(pd));
        check("last_eof", 32'(dst_if.strm_eof), 32'(pe));
        garbage(e);
        s_val[e] = 1'b1;
        s_eof[e] = 1'b1;

        if (mode == 0) begin
            w = $urandom_range(0, 2);
            repeat (w) begin
                cyc();
                check("wait_val", 32'(dst_if.strm_val), 0);
                check("wait_busy", 32'(busy), 1);
            end
            dst_if.ack = 1'b1;
            #1;
            check("src_ack", 32'(s_ack), 32'(one));
            dst_if.done = 1'b1;
            #1;
            check("src_done", 32'(s_done), 32'(one));
            cyc();
            dst_if.ack  = 1'b0;
            dst_if.done = 1'b0;
            check("done_idle", 32'(busy), 0);
            check("done_val", 32'(dst_if.strm_val), 0);
        end else if (mode == 1) begin
            dst_if.done = 1'b1;
            #1;
            check("early_done", 32'(s_done), 32'(one));
            cyc();
            dst_if.done = 1'b0;
            check("early_idle", 32'(busy), 0);
            check("early_drop", 32'(dst_if.strm_val), 0);
        end else begin
            s_val[e] = 1'b0;
            flag = 1'b0;
`ifdef UDP_VLG_TX_ARB_WATCHDOG_EN
            for (int k = 1; k < TIMEOUT; k++) begin
                if (to_err || s_done != '0 || !busy) flag = 1'b1;
                if (k > 1 && dst_if.strm_val) flag = 1'b1;
                garbage(e);
                cyc();
            end
            check("wd_quiet", 32'(flag), 0);
            check("wd_to_err", 32'(to_err), 1);
            check("wd_done", 32'(s_done), 32'(one));
            cyc();
            check("wd_beat", {dst_if.strm_val, dst_if.strm_eof, dst_if.strm_err}, 3'b111);
            check("wd_idle", 32'(busy), 0);
            check("wd_to_err_off", 32'(to_err), 0);
`else
            for (int k = 1; k < TIMEOUT + 50; k++) begin
                if (to_err || s_done != '0 || !busy) flag = 1'b1;
                garbage(e);
                cyc();
            end
            check("hang_quiet", 32'(flag), 0);
            check("hang_busy", 32'(busy), 1);
            dst_if.done = 1'b1;
            #1;
            check("hang_done", 32'(s_done), 32'(one));
            cyc();
            dst_if.done = 1'b0;
            check("hang_idle", 32'(busy), 0);
`endif
        end
        idle_srcs();
        ptr_m = (e + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        s_rdy       = '0;
        idle_srcs();
        for (int i = 0; i < N; i++) begin
            s_data[i] = '0;
            s_meta[i] = '0;
        end
        dst_if.req  = 1'b0;
        dst_if.ack  = 1'b0;
        dst_if.done = 1'b0;
        repeat (3) cyc();
        check("reset_busy", 32'(busy), 0);
        check("reset_gid", 32'(grant_id), 0);
        check("reset_to_err", 32'(to_err), 0);
        check("reset_rdy", 32'(dst_if.rdy), 0);
        check("reset_strm", {dst_if.strm_val, dst_if.strm_eof, dst_if.strm_err, dst_if.strm_data}, 0);
        check("reset_meta", dst_if.meta, 0);
        rst_n = 1'b1;

        repeat (4) dg('1, 3, 0, 1'b1);
        dg(3'b001, 10, 0, 1'b0);
        dg(3'b100, 8, 3, 1'b0);
        dg(3'b011, 3, 0, 1'b1);
        dg(3'b010, 4, 0, 1'b1);
        dg(3'b111, 4, 1, 1'b1);
        dg(3'b111, 3, 2, 1'b0);
        repeat (20) begin
            dg(3'($urandom_range(1, 7)), $urandom_range(1, 6), $urandom_range(0, 1), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/udp_vlg_tx_arb.md
# udp_vlg_tx_arb

Round-robin arbiter that shares the single UDP transmit path between `N` independent UDP transmit sources, such as DHCP, a user port and a debug/echo port. It sits between the sources and the UDP tx block. It grants one source per datagram, forwards that source's `rdy`/`meta` downstream, and returns `req` to it. It then pipes the source's payload stream and routes the completion handshake back to the winner. No datagram interleaving is possible.

## Interface
- `N`, 2: number of requesting sources, 2..8.
- `TIMEOUT`, 65535: watchdog limit in cycles; 16-bit counter.
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous, active-low reset.
- `src[N]` interface `udp.in_tx`: requesting sources.
  - `strm`, `meta` and `rdy` are inputs.
  - `req`, `ack` and `done` are outputs.
- `dst` interface `udp.out_tx`: toward the UDP tx block.
  - `strm`, `meta` and `rdy` are outputs.
  - `req`, `ack` and `done` are inputs.
- `grant_id` output `$clog2(N)`: index of the current or last owner.
- `busy` output 1: high in every state except IDLE.
- `to_err` output 1: one-cycle pulse on watchdog abort. Tied to 0 when the watchdog is compiled out.

## Operation
- **IDLE**
  - Sample `src[*].rdy`.
  - If any `rdy` is high, pick the first index at or after `ptr` (wrapping modulo N).
  - Register `sel` and latch `src[sel].meta` into `meta_q`, then go to GRANT.
  - `ptr` resets to 0. On every return to IDLE, `ptr` is set to `sel+1` modulo N.
- **GRANT**
  - `dst.rdy = 1` and `dst.meta = meta_q`.
  - When `dst.req = 1`:
    - Pulse `src[sel].req` for the same cycle (combinational route).
    - Deassert `dst.rdy` from the next cycle.
    - Go to STREAM.
- **STREAM**
  - `dst.strm` is `src[sel].strm`, registered, one-cycle latency.
  - Non-selected sources' streams are ignored.
  - When a beat with `val & eof` is accepted, go to WAIT.
- **WAIT**
  - `dst.strm.val = 0`.
  - `dst.done` and `dst.ack` are routed combinationally to `src[sel].done` and `src[sel].ack`.
  - Go to IDLE on `dst.done`.
- **Outputs to non-selected sources:** `req`, `ack` and `done` are always 0.
- **Held requests:** a source keeps `rdy` high until it receives `req`. A source that drops `rdy` during GRANT is not aborted; the datagram proceeds, because meta was already latched.
- **Source `err`:** `err` is forwarded unchanged with its beat; the arbiter takes no action.
- **Reset mid-operation:**
  - All state returns to IDLE with `ptr = 0`.
  - All outputs are 0, including `dst.strm` (all fields) and `dst.meta`.
  - No partial `req`, `done` or `ack` pulses are produced.
- **Reset values:** `grant_id = 0`, `busy = 0`, `to_err = 0`.

## Timing
- Request to `dst.rdy`: a `rdy` sampled in IDLE at cycle t gives `dst.rdy = 1` at t+1.
- `dst.req` to `src.req`: 0 cycles.
- Source beat at cycle t appears on `dst.strm` at t+1.
- Back-to-back datagrams: the cycle after `done`, the state is IDLE. The next grant is issued at the following cycle.
- Simultaneous `rdy` from all sources: service is strictly rotating. Each source waits at most N-1 datagrams.
- `done` arriving in STREAM (early abort by UDP tx):
  - Route `done` to the source and go to IDLE.
  - Drop the remaining source beats.

## Configuration
- `UDP_VLG_TX_ARB_WATCHDOG_EN`, when defined:
  - A 16-bit counter clears on state entry and increments every cycle in GRANT, STREAM and WAIT. In STREAM it also clears on each accepted beat.
  - When the counter reaches `TIMEOUT`:
    - Force `dst.strm.val = 1`, `eof = 1`, `err = 1` for one cycle, only if the timeout occurred in STREAM.
    - Pulse `src[sel].done` and `to_err`.
    - Go to IDLE and advance `ptr`.
- When not defined: no counter is present, `to_err = 0`, and the arbiter waits indefinitely.

## Test plan
- **Single source:** N=2 and only `src[0].rdy`. Expect `dst.rdy` at t+1 and `dst.meta` equal to src0's meta. Drive `dst.req`; expect `src[0].req` in the same cycle. Send 10 payload beats; expect all 10 on `dst.strm`, each delayed one cycle. `done` routes to src0 only, and `ptr` becomes 1.
- **Contention:** N=3 with all `rdy` held. Expect grant order 0,1,2,0 across four datagrams, and `grant_id` matches each one.
- **Isolation:** while src0 streams, src1 drives garbage `val` beats. Expect `dst.strm` to carry only src0 data, and src1's `req`, `ack` and `done` to stay 0.
- **Reset mid-STREAM:** pulse `rst_n` low for 1 cycle during beat 5. Expect IDLE next cycle, all outputs 0 and `ptr = 0`. A new `src[1].rdy` is then granted normally.
- **Watchdog (macro on, `TIMEOUT` = 100):** the source stops after 3 beats without `eof`. Expect at cycle 100 after the last beat:
  - one `dst.strm` beat with `eof = err = 1`;
  - a `to_err` pulse and `src.done`;
  - the next source granted. With the macro off, the arbiter stays in STREAM.
- **Early `done` in STREAM:** expect `src.done` at the same cycle, IDLE next cycle, and no further `dst.strm.val`.
